// File: rtl/uconv_if.sv
// Streaming port bundle for the upconverter: baseband in, LO in, RF out.
interface uconv_if;
  logic signed [15:0] bb;
  logic               bb_valid;
  logic               bb_ready;
  logic signed [15:0] lo;
  logic signed [15:0] out;
  logic               out_valid;
  logic               underrun;

  modport master (output bb, bb_valid, lo, input bb_ready, out, out_valid, underrun);
  modport slave  (input bb, bb_valid, lo, output bb_ready, out, out_valid, underrun);
endinterface

// File: rtl/uconv.sv
// Digital upconverter: zero-stuffing interpolator, NTAPS FIR, then LO mixer.
// i_rst is synchronous, active low.
module uconv #(
  parameter int NTAPS     = 64,
  parameter int INTERP    = 4,
  parameter int COEF_FRAC = 12
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NTAPS*16-1:0]  i_fir_coefs,
  uconv_if.slave               u
);
  localparam int PH_W   = $clog2(INTERP);
  localparam int ACC_W  = 33 + $clog2(NTAPS);
  localparam int SW     = ACC_W + PH_W;
  localparam int STAGES = 2;

  logic [PH_W-1:0]            r_phase;
  logic [NTAPS-1:0][15:0]     r_dl;
  logic signed [15:0]         r_fir;
  logic signed [15:0]         r_out;
  logic [STAGES:0]            r_vld_pipe;
  logic                       r_underrun;

  logic [NTAPS-1:0][15:0]     w_coef;
  logic [NTAPS-1:0][31:0]     w_prod;
  logic signed [ACC_W-1:0]    w_acc;
  logic signed [SW-1:0]       w_scaled;
  logic signed [SW-1:0]       w_shr;
  logic signed [15:0]         w_fir_sat;
  logic signed [31:0]         w_mix;
  logic signed [31:0]         w_mix_shr;
  logic signed [15:0]         w_mix_sat;
  logic                       w_ready;
  logic                       w_accept;
  logic [15:0]                w_din;

  assign w_coef   = i_fir_coefs;
  assign w_ready  = i_rst && (r_phase == '0);
  assign w_accept = w_ready && u.bb_valid;
  assign w_din    = w_accept ? u.bb : 16'd0;

  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    assign w_prod[k] = $signed(r_dl[k]) * $signed(w_coef[k]);
  end

  always_comb begin
    w_acc = '0;
    for (int k = 0; k < NTAPS; k++)
      w_acc = w_acc + {{(ACC_W-32){w_prod[k][31]}}, w_prod[k]};
  end

  // INTERP is a power of two, so the gain restore is a left shift
  assign w_scaled  = {w_acc, {PH_W{1'b0}}};
  assign w_shr     = w_scaled >>> COEF_FRAC;
  assign w_fir_sat = ((&w_shr[SW-1:15]) | ~(|w_shr[SW-1:15])) ? w_shr[15:0]
                   : (w_shr[SW-1] ? 16'sh8000 : 16'sh7fff);

  assign w_mix     = r_fir * u.lo;
  assign w_mix_shr = w_mix >>> 15;
  assign w_mix_sat = ((&w_mix_shr[31:15]) | ~(|w_mix_shr[31:15])) ? w_mix_shr[15:0]
                   : (w_mix_shr[31] ? 16'sh8000 : 16'sh7fff);

  // vld_pipe[0] doubles as the "started" flag; [STAGES] is out_valid
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_phase    <= '0;
      r_dl       <= '0;
      r_fir      <= '0;
      r_out      <= '0;
      r_vld_pipe <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_phase    <= r_phase + PH_W'(1);
      r_dl       <= {r_dl[NTAPS-2:0], w_din};
      r_fir      <= w_fir_sat;
      r_out      <= w_mix_sat;
      r_vld_pipe <= {r_vld_pipe[STAGES-1:0], r_vld_pipe[0] | w_accept};
      r_underrun <= (r_phase == '0) && r_vld_pipe[0] && !u.bb_valid;
    end
  end

  assign u.bb_ready  = w_ready;
  assign u.out       = r_out;
  assign u.out_valid = r_vld_pipe[STAGES];
  assign u.underrun  = r_underrun;
endmodule

// File: tb/tb_uconv.sv
// Self-checking bench for uconv against a sample-stream reference model.
module tb_uconv;
  localparam int NT = 16, IP = 4, CF = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NT*16-1:0]  coefs;
  uconv_if uif();

  uconv #(.NTAPS(NT), .INTERP(IP), .COEF_FRAC(CF)) dut (
    .i_clk(clk), .i_rst(rst), .i_fir_coefs(coefs), .u(uif.slave));

  int errors = 0, checks = 0;
  int coef[NT];

  // reference model: stream of inserted samples (newest first) plus timing counters
  longint xs[$];
  longint m_fir, m_out;
  int     m_n, m_since;
  bit     m_started, m_und;

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic set_coefs();
    for (int k = 0; k < NT; k++) coefs[k*16 +: 16] = 16'(coef[k]);
  endtask

  task automatic drive(input bit r, input bit v, input int b, input int l);
    rst = r; uif.bb_valid = v; uif.bb = 16'(b); uif.lo = 16'(l);
    #1;
  endtask

  task automatic tick();
    bit acc; longint sum; int ph;
    @(posedge clk);
    if (!rst) begin
      xs.delete(); m_fir = 0; m_out = 0; m_n = 0; m_since = 0; m_started = 0; m_und = 0;
    end else begin
      ph  = m_n % IP;
      acc = (ph == 0) && uif.bb_valid;
      m_out = sat16((m_fir * longint'(uif.lo)) >>> 15);
      sum = 0;
      foreach (xs[k]) sum += xs[k] * coef[k];
      m_fir = sat16((sum * IP) >>> CF);
      m_und = (ph == 0) && m_started && !uif.bb_valid;
      xs.push_front(acc ? longint'(uif.bb) : 0);
      if (xs.size() > NT) void'(xs.pop_back());
      if (m_started) m_since++;
      if (acc && !m_started) begin m_started = 1; m_since = 0; end
      m_n++;
    end
    #1;
  endtask

  task automatic do_reset(input int l);
    drive(0, 0, 0, l); tick(); tick();
    drive(1, 0, 0, l);
  endtask

  task automatic rand_coefs(input int mag);
    for (int k = 0; k < NT; k++) coef[k] = int'($urandom_range(0, 2*mag)) - mag;
    set_coefs();
  endtask

  task automatic test_reset();
    rand_coefs(2048);
    drive(0, 1, 1234, 1000);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks += 4;
      if (uif.out !== 16'sd0) begin errors++; $display("FAIL reset_out: got %0d want 0", uif.out); end
      if (uif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_ovld: got %b want 0", uif.out_valid); end
      if (uif.bb_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", uif.bb_ready); end
      if (uif.underrun !== 1'b0) begin errors++; $display("FAIL reset_und: got %b want 0", uif.underrun); end
    end
    drive(1, 0, 0, 1000);
    for (int i = 0; i < 12; i++) begin
      checks += 2;
      if (uif.bb_ready !== (i % IP == 0)) begin
        errors++; $display("FAIL release_ready[%0d]: got %b want %b", i, uif.bb_ready, (i % IP == 0));
      end
      if (uif.out_valid !== 1'b0) begin errors++; $display("FAIL release_ovld[%0d]: got %b want 0", i, uif.out_valid); end
      tick();
    end
  endtask

  task automatic test_impulse();
    for (int k = 0; k < NT; k++) coef[k] = 0;
    coef[0] = 4096; set_coefs();
    do_reset(32767);
    drive(1, 1, 4096, 32767); tick();
    drive(1, 0, 0, 32767);    tick();
    checks++;
    if (uif.out_valid !== 1'b0) begin errors++; $display("FAIL imp_ovld_e1: got %b want 0", uif.out_valid); end
    tick();
    checks += 2;
    if (uif.out !== 16'sd16383) begin errors++; $display("FAIL imp_out_e2: got %0d want 16383", uif.out); end
    if (uif.out_valid !== 1'b1) begin errors++; $display("FAIL imp_ovld_e2: got %b want 1", uif.out_valid); end
    for (int i = 3; i <= 5; i++) begin
      tick();
      checks += 2;
      if (uif.out !== 16'sd0) begin errors++; $display("FAIL imp_out_e%0d: got %0d want 0", i, uif.out); end
      if (uif.out_valid !== 1'b1) begin errors++; $display("FAIL imp_ovld_e%0d: got %b want 1", i, uif.out_valid); end
    end
  endtask

  task automatic test_dc_gain();
    for (int k = 0; k < NT; k++) coef[k] = (k < 4) ? 1024 : 0;
    set_coefs();
    do_reset(32767);
    drive(1, 1, 1000, 32767);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i >= 8) begin
        checks += 3;
        if (uif.out !== 16'sd999) begin errors++; $display("FAIL dc_out[%0d]: got %0d want 999", i, uif.out); end
        if (longint'(uif.out) != m_out) begin errors++; $display("FAIL dc_model[%0d]: got %0d want %0d", i, uif.out, m_out); end
        if (uif.underrun !== 1'b0) begin errors++; $display("FAIL dc_und[%0d]: got %b want 0", i, uif.underrun); end
      end
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < NT; k++) coef[k] = 0;
    coef[0] = 32767; set_coefs();
    do_reset(-32768);
    drive(1, 1, 32767, -32768); tick();
    drive(1, 0, 0, -32768);     tick(); tick();
    checks++;
    if (uif.out !== -16'sd32767) begin errors++; $display("FAIL sat_pos: got %0d want -32767", uif.out); end
    tick();
    drive(1, 1, -32768, -32768); tick();
    drive(1, 0, 0, -32768);      tick(); tick();
    checks += 2;
    if (uif.out !== 16'sd32767) begin errors++; $display("FAIL sat_neg: got %0d want 32767", uif.out); end
    if (longint'(uif.out) != m_out) begin errors++; $display("FAIL sat_model: got %0d want %0d", uif.out, m_out); end
  endtask

  task automatic test_underrun();
    int pulses = 0;
    rand_coefs(1024);
    do_reset(20000);
    for (int i = 0; i < 40; i++) begin
      drive(1, (i != 16), int'($urandom_range(0, 8000)) - 4000, 20000);
      checks++;
      if (uif.bb_ready !== (i % IP == 0)) begin
        errors++; $display("FAIL und_ready[%0d]: got %b want %b", i, uif.bb_ready, (i % IP == 0));
      end
      tick();
      if (uif.underrun === 1'b1) pulses++;
      checks += 2;
      if (uif.underrun !== (i == 16)) begin errors++; $display("FAIL und_pulse[%0d]: got %b want %b", i, uif.underrun, (i == 16)); end
      if (longint'(uif.out) != m_out) begin errors++; $display("FAIL und_out[%0d]: got %0d want %0d", i, uif.out, m_out); end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL und_count: got %0d want 1", pulses); end
  endtask

  task automatic test_midreset();
    rand_coefs(1024);
    do_reset(15000);
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, int'($urandom_range(0, 8000)) - 4000, 15000); tick();
    end
    drive(0, 1, 500, 15000); tick();
    checks += 2;
    if (uif.out !== 16'sd0) begin errors++; $display("FAIL mrst_out: got %0d want 0", uif.out); end
    if (uif.out_valid !== 1'b0) begin errors++; $display("FAIL mrst_ovld: got %b want 0", uif.out_valid); end
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 15000); tick();
      checks++;
      if (uif.underrun !== 1'b0) begin errors++; $display("FAIL mrst_und[%0d]: got %b want 0", i, uif.underrun); end
    end
    for (int k = 0; k < 10; k++) begin
      drive(1, 1, int'($urandom_range(0, 8000)) - 4000, 15000); tick();
      checks += 2;
      if (uif.out_valid !== (k >= 2)) begin errors++; $display("FAIL mrst_resume[%0d]: got %b want %b", k, uif.out_valid, (k >= 2)); end
      if (longint'(uif.out) != m_out) begin errors++; $display("FAIL mrst_out[%0d]: got %0d want %0d", k, uif.out, m_out); end
    end
  endtask

  task automatic test_random();
    bit r, v;
    rand_coefs(4096);
    do_reset(0);
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) != 0);
      v = ($urandom_range(0, 3) != 0);
      drive(r, v, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
      checks++;
      if (uif.bb_ready !== (r && (m_n % IP == 0))) begin
        errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, uif.bb_ready, (r && (m_n % IP == 0)));
      end
      tick();
      checks += 3;
      if (longint'(uif.out) != m_out) begin errors++; $display("FAIL rnd_out[%0d]: got %0d want %0d", i, uif.out, m_out); end
      if (uif.out_valid !== (m_started && m_since >= 2)) begin
        errors++; $display("FAIL rnd_ovld[%0d]: got %b want %b", i, uif.out_valid, (m_started && m_since >= 2));
      end
      if (uif.underrun !== m_und) begin errors++; $display("FAIL rnd_und[%0d]: got %b want %b", i, uif.underrun, m_und); end
    end
  endtask

  initial begin
    rst = 1'b0; coefs = '0; uif.bb = '0; uif.bb_valid = 1'b0; uif.lo = '0;
    test_reset();
    test_impulse();
    test_dc_gain();
    test_saturation();
    test_underrun();
    test_midreset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uconv.md
UCONV -- requirements
Module: uconv

Interface
REQ-001 Parameter NTAPS, default 64: number of FIR taps.
REQ-002 Parameter INTERP, default 4: interpolation factor; power of two, 2..16.
REQ-003 Parameter COEF_FRAC, default 12: fractional bits of the signed coefficients.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: synchronous, active-low reset; sampled on the rising edge of clk.
REQ-006 fir_coefs  input  NTAPS*16: coefficient bus; bits [16k+15:16k] hold signed coefficient c[k]; static during operation.
REQ-007 bb  input  16: signed baseband sample.
REQ-008 bb_valid  input  1: bb holds a sample.
REQ-009 bb_ready  output  1: block accepts bb in this cycle.
REQ-010 lo  input  16: signed local-oscillator sample, one per clk.
REQ-011 out  output  16: signed upconverted RF sample, one per clk.
REQ-012 out_valid  output  1: out carries filtered data.
REQ-013 underrun  output  1: one-cycle pulse when a baseband sample was due but absent.

Function
REQ-014 Phase counter: 0..INTERP-1, increments every cycle, wraps INTERP-1 -> 0.
REQ-015 bb_ready: high only when phase==0 and not in reset; combinational from the phase register.
REQ-016 Accept: bb_valid & bb_ready on edge E -> bb shifted into delay-line tap d[0]; d[k] -> d[k+1]; d[NTAPS-1] discarded.
REQ-017 Zero stuffing: phases 1..INTERP-1 -> zero shifted into d[0].
REQ-018 Phase 0 with bb_valid low -> zero shifted into d[0].
REQ-019 started flag: set on the first accept; cleared only by reset.
REQ-020 underrun: pulses high for the cycle after a phase-0 edge with started=1 and bb_valid=0; otherwise 0.
REQ-021 FIR stage register fir_r (16 bit):
- acc = sum over k of d[k]*c[k], full precision (at least 38 bits signed).
- fir_r = sat16((acc * INTERP) >>> COEF_FRAC), updated every edge.
REQ-022 Mixer stage: out = sat16((fir_r*lo) >>> 15), registered every edge.
- lo is the value present in the cycle before the edge.
REQ-023 All right shifts are arithmetic (floor); sat16 clamps to [-32768, 32767].
REQ-024 Latency: sample accepted on edge E first contributes to fir_r on E+1 and to out on E+2.
REQ-025 out_valid: rises on edge E+2 after the first accept; stays high until reset.
REQ-026 Simultaneous events: bb_valid held high during phases 1..INTERP-1 is ignored; no sample is consumed.

Reset
REQ-027 rst low at an edge clears, at that same edge:
- phase to 0 and started to 0;
- all d[k], fir_r and out to 0;
- out_valid and underrun to 0.
REQ-028 bb_ready is 0 while rst is low.
REQ-029 Reset mid-stream discards all in-flight samples; the first accept after release restarts the REQ-024 timing.

Verification
REQ-030 Reset: rst=0 for 10 cycles, then rst=1.
- During reset: out=0, out_valid=0, bb_ready=0, underrun=0.
- bb_ready=1 in the first cycle after release and every INTERP-th cycle after that.
REQ-031 Impulse: INTERP=4, c[0]=4096, other taps 0, lo=32767, one sample bb=4096 accepted on E.
- out=16383 on E+2; out=0 on E+3..E+5; out_valid=1 from E+2.
REQ-032 DC gain: c[0..3]=1024, other taps 0, lo=32767, continuous bb=1000.
- Steady-state out=999 on every cycle.
REQ-033 Saturation:
- c[0]=32767, bb=32767, lo=-32768 -> fir_r=32767, out=-32767.
- bb=-32768 (fir_r=-32768), lo=-32768 -> out=32767.
REQ-034 Underrun: after started, deassert bb_valid for one phase-0 slot.
- underrun=1 for exactly one cycle; a zero is inserted; phase is unaffected; no further pulse when bb_valid returns.
REQ-035 Mid-stream reset: rst=0 for 1 cycle during continuous streaming.
- Next cycle: out=0, out_valid=0, started=0.
- Output resumes exactly 2 edges after the next accept.
